// File: rtl/level_ramp_if.sv
// level_ramp_if: I2S timing, volume request and applied level between controller and level_ramp
interface level_ramp_if;
    logic       bclk;
    logic       lrclk;
    logic [6:0] target;
    logic [3:0] rate;
    logic       mute;
    logic [6:0] level;
    logic       busy;
    logic       muted;
    modport master (output bclk, lrclk, target, rate, mute, input level, busy, muted);
    modport slave  (input bclk, lrclk, target, rate, mute, output level, busy, muted);
endinterface

// File: rtl/level_ramp.sv
// level_ramp: steps the mixer level toward a clamped/muted target, one step per (rate+1) I2S frames
module level_ramp #(
    parameter int LEVEL_MAX  = 82,
    parameter int LEVEL_INIT = 0
) (
    input logic         clk,
    input logic         rst,
    level_ramp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
    localparam logic [6:0] MAXV  = 7'(LEVEL_MAX);
    localparam logic [6:0] INITV = 7'(LEVEL_INIT);
    state_t     state, state_n;
    logic [6:0] level_q, level_n, eff;
    logic [3:0] cnt, cnt_n;
    logic       lrclk_prev, tick, busy_q, muted_q, unused;
    assign unused = bus.bclk;
    assign eff  = bus.mute ? 7'd0 : (bus.target > MAXV ? MAXV : bus.target);
    assign tick = lrclk_prev & ~bus.lrclk;
    // A state change wins over a coincident tick, so steps only happen in a settled UP/DOWN state
    always_comb begin
        state_n = eff > level_q ? UP : (eff < level_q ? DOWN : IDLE);
        level_n = level_q;
        cnt_n   = cnt;
        if (state_n != state || state_n == IDLE)
            cnt_n = 4'd0;
        else if (tick) begin
            cnt_n   = cnt == bus.rate ? 4'd0 : cnt + 4'd1;
            level_n = cnt != bus.rate ? level_q : (state == UP ? level_q + 7'd1 : level_q - 7'd1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            level_q    <= INITV;
            cnt        <= 4'd0;
            lrclk_prev <= 1'b1;
            busy_q     <= 1'b0;
            muted_q    <= 1'b0;
        end else begin
            state      <= state_n;
            level_q    <= level_n;
            cnt        <= cnt_n;
            lrclk_prev <= bus.lrclk;
            busy_q     <= state_n != IDLE;
            muted_q    <= bus.mute && level_n == 7'd0 && state_n == IDLE;
        end
    end
    assign bus.level = level_q;
    assign bus.busy  = busy_q;
    assign bus.muted = muted_q;
endmodule

// File: tb/tb_level_ramp.sv
// tb_level_ramp: directed ramp, clamp, reversal, mute and reset scenarios for level_ramp
module tb_level_ramp;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errs = 0;
    level_ramp_if bus();
    level_ramp dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Ends on the negedge right after the falling-lrclk edge
    task automatic frame_to_tick();
        bus.lrclk = 1'b1;
        clk_n(2);
        bus.lrclk = 1'b0;
        clk_n(1);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_to_tick();
            clk_n(1);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.bclk = 1'b0;
        bus.lrclk = 1'b0;
        bus.target = 7'd0;
        bus.rate = 4'd0;
        bus.mute = 1'b0;
        clk_n(3);
        chk("reset_level", bus.level, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_muted", bus.muted, 0);
        rst = 1'b0;
        bus.target = 7'd5;
        clk_n(3);
        chk("no_tick_after_reset", bus.level, 0);
        chk("busy_up", bus.busy, 1);
        for (int k = 1; k <= 5; k++) begin
            bus.lrclk = 1'b1;
            clk_n(2);
            chk("hold_between_ticks", bus.level, k - 1);
            bus.lrclk = 1'b0;
            clk_n(1);
            chk("basic_step", bus.level, k);
            chk("busy_at_step", bus.busy, 1);
            clk_n(1);
        end
        chk("busy_drop", bus.busy, 0);
        bus.target = 7'd80;
        frames(76);
        chk("reach_80", bus.level, 80);
        chk("idle_80", bus.busy, 0);
        bus.target = 7'd100;
        bus.rate = 4'd3;
        clk_n(1);
        frames(3);
        chk("slow_3_ticks", bus.level, 80);
        frames(1);
        chk("slow_4_ticks", bus.level, 81);
        frames(4);
        chk("slow_8_ticks", bus.level, 82);
        frames(4);
        chk("clamp_hold", bus.level, 82);
        chk("clamp_busy", bus.busy, 0);
        bus.target = 7'd40;
        bus.rate = 4'd0;
        frames(45);
        chk("reach_40", bus.level, 40);
        bus.target = 7'd60;
        bus.rate = 4'd1;
        clk_n(1);
        frames(1);
        chk("rev_up_partial", bus.level, 40);
        bus.target = 7'd30;
        clk_n(1);
        frames(1);
        chk("rev_cnt_cleared", bus.level, 40);
        frames(1);
        chk("rev_first_down", bus.level, 39);
        frames(18);
        chk("rev_reach_30", bus.level, 30);
        chk("rev_idle", bus.busy, 0);
        bus.target = 7'd20;
        bus.rate = 4'd0;
        frames(10);
        chk("reach_20", bus.level, 20);
        bus.rate = 4'd1;
        bus.mute = 1'b1;
        clk_n(1);
        frames(39);
        chk("mute_39_ticks", bus.level, 1);
        frame_to_tick();
        chk("mute_40_ticks", bus.level, 0);
        chk("muted_not_yet", bus.muted, 0);
        clk_n(1);
        chk("muted_set", bus.muted, 1);
        chk("muted_idle", bus.busy, 0);
        bus.mute = 1'b0;
        clk_n(1);
        chk("muted_clear", bus.muted, 0);
        chk("unmute_busy", bus.busy, 1);
        frames(2);
        chk("unmute_ramp", bus.level, 1);
        bus.target = 7'd70;
        bus.rate = 4'd0;
        frames(32);
        chk("reach_33", bus.level, 33);
        chk("ramp_33_busy", bus.busy, 1);
        rst = 1'b1;
        clk_n(1);
        chk("midramp_reset_level", bus.level, 0);
        chk("midramp_reset_busy", bus.busy, 0);
        rst = 1'b0;
        clk_n(1);
        chk("resume_busy", bus.busy, 1);
        frames(3);
        chk("resume_level", bus.level, 3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/level_ramp.md
# level_ramp

Volume level sequencer that drives the 7-bit `level` input of the bit-serial mixer. It moves the applied level one table step at a time toward a requested target, and it updates only on I2S frame boundaries, so the mixer's gain never changes inside a sample word. The block removes zipper noise on volume changes and provides a clean ramp-to-minimum mute. It sits in the `clk` domain between the control registers and the mixer.

## Interface
- `LEVEL_MAX`, 82: highest valid mixer table index. Targets above it are clamped.
- `LEVEL_INIT`, 0: `level` value loaded at reset.
- `clk` input 1: system clock. `bclk` and `lrclk` are synchronous to it.
- `rst` input 1: synchronous, active-high reset.
- `bclk` input 1: I2S bit clock. Passed through only for port symmetry with mixer stages; not used internally.
- `lrclk` input 1: I2S word clock. Its falling edge is the frame boundary.
- `target` input 7: requested level. Sampled every `clk`.
- `rate` input 4: frames per step minus 1 (0 = one step per frame, 15 = one step per 16 frames).
- `mute` input 1: forces the effective target to 0.
- `level` output 7: registered level applied to the mixer.
- `busy` output 1: high while ramping (state UP or DOWN).
- `muted` output 1: high when `mute`=1, `level`=0 and state is IDLE.

## Operation
- Effective target: eff = `mute` ? 0 : min(`target`, `LEVEL_MAX`). It is combinational from the current inputs.
- Frame tick: `lrclk_prev` is a register copy of `lrclk`. tick = `lrclk_prev` & ~`lrclk`. There is exactly one tick per frame.
- FSM states: IDLE, UP, DOWN. The state register updates every `clk`, not only on ticks.
  - Any state -> UP when eff > `level` and not already UP. Clear `cnt` on entry.
  - Any state -> DOWN when eff < `level` and not already DOWN. Clear `cnt` on entry.
  - Any state -> IDLE when eff == `level`. Clear `cnt`.
  - Reversal (UP<->DOWN) goes directly to the new state with `cnt` cleared. It does not pass through IDLE.
- Frame counter `cnt` (4 bits), in UP or DOWN, on a tick:
  - If `cnt` == `rate`: `level` moves one step toward eff (+1 in UP, -1 in DOWN) and `cnt` returns to 0.
  - Otherwise: `cnt` increments.
- A step never overshoots, because the step is ±1 and the state is re-evaluated every cycle.
- `level` changes only on a tick edge, and by at most 1 per tick.
- `level` stays within 0..`LEVEL_MAX` at all times. It never wraps.
- A change of `rate` mid-ramp takes effect at the next comparison. If `cnt` > the new `rate`, `cnt` counts up, wraps 15->0 and continues; no step is lost beyond that wrap.
- `target` changes between ticks are absorbed. Only the eff value present on the tick edge decides whether a step occurs.
- Simultaneous events:
  - Tick and an FSM transition on the same edge: the transition wins. The state and `cnt` update, `level` does not step, and the first step follows the normal `cnt` rule.
  - Tick in IDLE: no action.

## Timing
- Reset values (`rst`=1 on a `clk` edge):
  - `level`=`LEVEL_INIT`, state=IDLE, `cnt`=0.
  - `lrclk_prev`=1, so a low `lrclk` right after reset does not generate a tick.
  - `busy`=0. `muted`=0 (registered, evaluated from the first post-reset cycle).
- Reset mid-ramp: the ramp is abandoned and `level` jumps to `LEVEL_INIT` on that edge.
- `busy` and `muted` are registered. They reflect the state one `clk` after the condition.
- Step latency: with state already UP or DOWN and `cnt`=`rate`, `level` updates on the first `clk` edge at which `lrclk` is sampled 0 after being 1.
- Ramp duration for N steps, starting in IDLE: (N·(`rate`+1)) ticks, counted from the first tick after the state enters UP or DOWN.

## Test plan
- Reset check: hold `rst` 3 cycles with `LEVEL_INIT`=0 -> `level`=0, `busy`=0, `muted`=0. No tick on the first low `lrclk`.
- Basic ramp: `target`=5, `rate`=0, one tick per 64 clk -> `level` steps 1,2,3,4,5 on 5 consecutive ticks. `busy` drops one clk after `level`=5. No `level` change between ticks.
- Slow ramp with clamp: `target`=100, `rate`=3, start at 80 -> `level` goes 81 after 4 ticks, 82 after 8 ticks, then holds at 82 (clamped). `busy`=0.
- Reversal: ramping up at `level`=40 toward 60, then set `target`=30 -> state DOWN with `cnt` cleared. `level` reaches 30 after 10·(`rate`+1) ticks with no value above 40.
- Mute: at `level`=20 with `rate`=1, assert `mute` -> `level` reaches 0 after 40 ticks and `muted`=1 one clk later. Deassert `mute` with `target`=20 -> ramp back up, `muted`=0.
- Reset mid-ramp: assert `rst` while `level`=33 is ramping to 70 -> next edge `level`=`LEVEL_INIT`, `busy`=0. After release the ramp resumes from `LEVEL_INIT`.
